// File: rtl/memoria_loader_pkg.sv
// Shared types and constants for the program-memory loader: FSM states,
// error codes and the default frame start marker.
package memoria_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_LO = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_CNT_LO  = 3'd3,
        ST_CNT_HI  = 3'd4,
        ST_DATA    = 3'd5,
        ST_CSUM    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/memoria_programa_loader_if.sv
// Byte-stream input and program-memory write port bundles used by the loader.
interface loader_stream_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

interface loader_mem_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;

    modport master (
        output mem_address, output mem_byteenable, output mem_chipselect,
        output mem_write, output mem_writedata
    );
    modport slave (
        input mem_address, input mem_byteenable, input mem_chipselect,
        input mem_write, input mem_writedata
    );
endinterface

// File: rtl/memoria_programa_loader_timeout.sv
// Inter-byte idle timer: counts while enabled, saturates at TIMEOUT_CYCLES-1.
module loader_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/memoria_programa_loader.sv
// Frame parser that packs a little-endian byte stream into 32-bit program
// memory writes and releases the CPU reset once a frame checks out.
module memoria_programa_loader
    import memoria_loader_pkg::*;
#(
    parameter int         ADDR_W         = 14,
    parameter int         DEPTH          = 16384,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter bit         HOLD_AT_RESET  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    loader_stream_if.slave   stream,
    loader_mem_if.master     mem,
    output logic             cpu_reset_req,
    output logic             load_done,
    output logic             load_error,
    output logic [1:0]       error_code
);

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t            state, state_nxt;
    logic [7:0]        sum, sum_nxt;
    logic [15:0]       addr_field, addr_nxt;
    logic [7:0]        cnt_lo, cnt_lo_nxt;
    logic [15:0]       words_left, words_left_nxt;
    logic [1:0]        byte_idx, byte_idx_nxt;
    logic [23:0]       shift, shift_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [31:0]       wr_data, wr_data_nxt;
    logic              wr_stb, wr_stb_nxt;
    logic              cpu_rst_nxt, done_nxt, error_nxt;
    err_code_t         code_nxt;

    logic              accept;
    logic [7:0]        in_byte;
    logic              expired;
    logic [15:0]       cnt_full;

    // Upper bits of the address field beyond ADDR_W are ignored; the
    // 17-bit sum cannot overflow for any 16-bit base and count.
    function automatic logic frame_fits(input logic [15:0] base, input logic [15:0] count);
        logic [16:0] last;
        last = 17'(base[ADDR_W-1:0]) + 17'(count);
        return (count != 16'd0) && (last <= DEPTH_LIM);
    endfunction

    assign stream.in_ready     = 1'b1;
    assign accept              = stream.in_valid;
    assign in_byte             = stream.in_data;
    assign cnt_full            = {in_byte, cnt_lo};

    assign mem.mem_address     = wr_addr;
    assign mem.mem_writedata   = wr_data;
    assign mem.mem_write       = wr_stb;
    assign mem.mem_chipselect  = wr_stb;
    assign mem.mem_byteenable  = {4{wr_stb}};

    loader_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept || (state == ST_IDLE)),
        .enable  (state != ST_IDLE),
        .expired (expired)
    );

    always_comb begin
        state_nxt      = state;
        sum_nxt        = sum;
        addr_nxt       = addr_field;
        cnt_lo_nxt     = cnt_lo;
        words_left_nxt = words_left;
        byte_idx_nxt   = byte_idx;
        shift_nxt      = shift;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        wr_stb_nxt     = 1'b0;
        cpu_rst_nxt    = cpu_reset_req;
        done_nxt       = 1'b0;
        error_nxt      = 1'b0;
        code_nxt       = err_code_t'(error_code);

        if (wr_stb) begin
            wr_addr_nxt = wr_addr + ADDR_W'(1);
        end

        if (accept) begin
            if (state != ST_IDLE) begin
                sum_nxt = sum + in_byte;
            end
            unique case (state)
                ST_IDLE: begin
                    if (in_byte == SYNC_BYTE) begin
                        state_nxt   = ST_ADDR_LO;
                        cpu_rst_nxt = 1'b1;
                        code_nxt    = ERR_NONE;
                        sum_nxt     = 8'h00;
                    end
                end
                ST_ADDR_LO: begin
                    addr_nxt[7:0] = in_byte;
                    state_nxt     = ST_ADDR_HI;
                end
                ST_ADDR_HI: begin
                    addr_nxt[15:8] = in_byte;
                    state_nxt      = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    cnt_lo_nxt = in_byte;
                    state_nxt  = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    if (frame_fits(addr_field, cnt_full)) begin
                        wr_addr_nxt    = addr_field[ADDR_W-1:0];
                        words_left_nxt = cnt_full;
                        byte_idx_nxt   = 2'd0;
                        state_nxt      = ST_DATA;
                    end else begin
                        error_nxt = 1'b1;
                        code_nxt  = ERR_RANGE;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    byte_idx_nxt = byte_idx + 2'd1;
                    unique case (byte_idx)
                        2'd0: shift_nxt[7:0]   = in_byte;
                        2'd1: shift_nxt[15:8]  = in_byte;
                        2'd2: shift_nxt[23:16] = in_byte;
                        2'd3: begin
                            wr_data_nxt    = {in_byte, shift};
                            wr_stb_nxt     = 1'b1;
                            words_left_nxt = words_left - 16'd1;
                            if (words_left == 16'd1) begin
                                state_nxt = ST_CSUM;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_CSUM: begin
                    // The last word's write strobe is already on the bus here.
                    if (sum_nxt == 8'h00) begin
                        done_nxt    = 1'b1;
                        cpu_rst_nxt = 1'b0;
                    end else begin
                        error_nxt = 1'b1;
                        code_nxt  = ERR_CSUM;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if ((state != ST_IDLE) && expired) begin
            error_nxt = 1'b1;
            code_nxt  = ERR_TIMEOUT;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_stb        <= 1'b0;
            cpu_reset_req <= HOLD_AT_RESET;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            error_code    <= ERR_NONE;
        end else begin
            state         <= state_nxt;
            wr_addr       <= wr_addr_nxt;
            wr_data       <= wr_data_nxt;
            wr_stb        <= wr_stb_nxt;
            cpu_reset_req <= cpu_rst_nxt;
            load_done     <= done_nxt;
            load_error    <= error_nxt;
            error_code    <= code_nxt;
        end
    end

    // Frame datapath; every field is reloaded before use, so no reset needed.
    always_ff @(posedge clk) begin
        sum        <= sum_nxt;
        addr_field <= addr_nxt;
        cnt_lo     <= cnt_lo_nxt;
        words_left <= words_left_nxt;
        byte_idx   <= byte_idx_nxt;
        shift      <= shift_nxt;
    end

endmodule

// File: tb/tb_memoria_programa_loader.sv
// Bench for memoria_programa_loader: table of frames plus timeout and
// mid-frame reset sequences, with a write scoreboard.
module tb_memoria_programa_loader;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_reset_req, load_done, load_error;
    logic [1:0] error_code;

    loader_stream_if sif ();
    loader_mem_if #(.ADDR_W(14)) mif ();

    memoria_programa_loader #(
        .ADDR_W         (14),
        .DEPTH          (16384),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .HOLD_AT_RESET  (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stream        (sif),
        .mem           (mif),
        .cpu_reset_req (cpu_reset_req),
        .load_done     (load_done),
        .load_error    (load_error),
        .error_code    (error_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      addr;
        logic [15:0]      cnt;
        logic [3:0][31:0] w;
        logic [7:0]       csum_delta;
        logic             garbage;
        logic             send_data;
        logic             exp_done;
        logic [1:0]       exp_code;
        logic             exp_cpu;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [45:0] exp_q[$];
    logic [7:0]  run_sum;
    vec_t        vecs[9];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] c,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [7:0] d, input logic g, input logic sd,
                                input logic ed, input logic [1:0] ec, input logic cpu);
        vec_t v;
        v.addr = a; v.cnt = c; v.w = {w3, w2, w1, w0}; v.csum_delta = d;
        v.garbage = g; v.send_data = sd; v.exp_done = ed; v.exp_code = ec; v.exp_cpu = cpu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        logic [45:0] e;
        @(posedge clk);
        #1;
        if (load_done === 1'b1) done_cnt++;
        if (load_error === 1'b1) err_cnt++;
        if (load_done === 1'b1 || load_error === 1'b1)
            chk("pulse_exclusive", {63'd0, load_done & load_error}, 64'd0);
        if (mif.mem_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h/%0h required=none",
                         mif.mem_address, mif.mem_writedata);
            end else begin
                e = exp_q.pop_front();
                chk("mem_write", {13'd0, mif.mem_byteenable, mif.mem_chipselect,
                                  mif.mem_address, mif.mem_writedata},
                    {13'd0, 4'hF, 1'b1, e});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        step();
        sif.in_valid = 1'b0;
    endtask

    task automatic send_sum(input logic [7:0] b);
        run_sum = run_sum + b;
        send_byte(b);
    endtask

    task automatic send_header(input logic [15:0] a, input logic [15:0] c);
        send_byte(8'hA5);
        run_sum = 8'h00;
        send_sum(a[7:0]);
        send_sum(a[15:8]);
        send_sum(c[7:0]);
        send_sum(c[15:8]);
    endtask

    task automatic send_frame(input vec_t v);
        logic [13:0] wa;
        if (v.garbage) begin
            send_byte(8'h00);
            send_byte(8'hFF);
            send_byte(8'h5A);
        end
        send_header(v.addr, v.cnt);
        if (v.send_data) begin
            for (int i = 0; i < int'(v.cnt); i++) begin
                wa = v.addr[13:0] + 14'(i);
                exp_q.push_back({wa, v.w[i]});
                for (int b = 0; b < 4; b++) send_sum(v.w[i][8*b +: 8]);
            end
            send_byte(8'h00 - run_sum + v.csum_delta);
        end
    endtask

    initial begin
        int d0, e0;
        sif.in_data  = 8'h00;
        sif.in_valid = 1'b0;

        vecs[0] = mk(16'h0010, 16'd2, 32'h11223344, 32'h55667788, 0, 0, 8'h00, 0, 1, 1, 2'd0, 0);
        vecs[1] = mk(16'h0010, 16'd2, 32'h11223344, 32'h55667788, 0, 0, 8'h01, 0, 1, 0, 2'd2, 1);
        vecs[2] = mk(16'h3FFF, 16'd2, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd1, 1);
        vecs[3] = mk(16'h0000, 16'd0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 2'd1, 1);
        vecs[4] = mk(16'h3FFE, 16'd2, 32'hA5A5A5A5, 32'h00FF00FF, 0, 0, 8'h00, 0, 1, 1, 2'd0, 0);
        vecs[5] = mk(16'hC005, 16'd1, 32'h12345678, 0, 0, 0, 8'h00, 0, 1, 1, 2'd0, 0);
        vecs[6] = mk(16'h0100, 16'd4, 32'h01020304, 32'hA0B0C0D0, 32'hFFFFFFFF, 32'h0,
                     8'h00, 1, 1, 1, 2'd0, 0);
        vecs[7] = mk(16'h3FFF, 16'd1, 32'hDEADBEEF, 0, 0, 0, 8'h00, 1, 1, 1, 2'd0, 0);
        vecs[8] = mk(16'h0200, 16'd3, 32'h1, 32'h2, 32'h3, 0, 8'hFF, 0, 1, 0, 2'd2, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset_req", {63'd0, cpu_reset_req}, 64'd1);
        chk("rst_load_done", {63'd0, load_done}, 64'd0);
        chk("rst_load_error", {63'd0, load_error}, 64'd0);
        chk("rst_error_code", {62'd0, error_code}, 64'd0);
        chk("rst_mem", {13'd0, mif.mem_write, mif.mem_chipselect, mif.mem_byteenable,
                        mif.mem_address, mif.mem_writedata}, 64'd0);
        chk("in_ready", {63'd0, sif.in_ready}, 64'd1);
        reset_n = 1'b1;
        step();

        for (int k = 0; k < 9; k++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[k]);
            repeat (3) step();
            chk($sformatf("v%0d_done", k), 64'(done_cnt - d0), {63'd0, vecs[k].exp_done});
            chk($sformatf("v%0d_error", k), 64'(err_cnt - e0), {63'd0, ~vecs[k].exp_done});
            chk($sformatf("v%0d_code", k), {62'd0, error_code}, {62'd0, vecs[k].exp_code});
            chk($sformatf("v%0d_cpu", k), {63'd0, cpu_reset_req}, {63'd0, vecs[k].exp_cpu});
            chk($sformatf("v%0d_pending", k), 64'(exp_q.size()), 64'd0);
        end

        // Stall after the third data byte until the timer fires.
        e0 = err_cnt;
        send_header(16'h0020, 16'd1);
        send_sum(8'hBE);
        send_sum(8'hBA);
        send_sum(8'hFE);
        repeat (TO - 1) step();
        chk("to_not_yet", {63'd0, load_error}, 64'd0);
        step();
        chk("to_fire", {63'd0, load_error}, 64'd1);
        chk("to_code", {62'd0, error_code}, 64'd3);
        repeat (2) step();
        chk("to_cpu", {63'd0, cpu_reset_req}, 64'd1);
        chk("to_err_count", 64'(err_cnt - e0), 64'd1);

        // Same stall, but a byte lands on the cycle the timer would fire.
        d0 = done_cnt;
        e0 = err_cnt;
        send_header(16'h0020, 16'd1);
        send_sum(8'hBE);
        send_sum(8'hBA);
        send_sum(8'hFE);
        repeat (TO - 1) step();
        exp_q.push_back({14'h0020, 32'hCAFEBABE});
        send_sum(8'hCA);
        send_byte(8'h00 - run_sum);
        repeat (3) step();
        chk("tw_err_count", 64'(err_cnt - e0), 64'd0);
        chk("tw_done", 64'(done_cnt - d0), 64'd1);
        chk("tw_cpu", {63'd0, cpu_reset_req}, 64'd0);
        chk("tw_pending", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of the second data word.
        send_header(16'h0040, 16'd2);
        exp_q.push_back({14'h0040, 32'h0BADF00D});
        send_sum(8'h0D);
        send_sum(8'hF0);
        send_sum(8'hAD);
        send_sum(8'h0B);
        send_sum(8'h11);
        send_sum(8'h22);
        reset_n = 1'b0;
        #2;
        chk("mr_cpu", {63'd0, cpu_reset_req}, 64'd1);
        chk("mr_pulses", {62'd0, load_done, load_error}, 64'd0);
        chk("mr_code", {62'd0, error_code}, 64'd0);
        chk("mr_mem", {13'd0, mif.mem_write, mif.mem_chipselect, mif.mem_byteenable,
                       mif.mem_address, mif.mem_writedata}, 64'd0);
        chk("mr_pending", 64'(exp_q.size()), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(vecs[0]);
        repeat (3) step();
        chk("mr_after_done", 64'(done_cnt - d0), 64'd1);
        chk("mr_after_err", 64'(err_cnt - e0), 64'd0);
        chk("mr_after_cpu", {63'd0, cpu_reset_req}, 64'd0);
        chk("mr_after_pending", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
